// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared constants and types for the single-cycle processor datapath.
//   This package provides the register-file geometry (DATA_W, ADDR_W and
//   NUM_REGS), the hardwired zero register index, and the named architectural
//   register indices that the control unit uses.
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0] reg_word_t;

   // Architectural register indices
   localparam reg_idx_t ZERO_REG = 5'd0;
   localparam reg_idx_t GP       = 5'd28;
   localparam reg_idx_t SP       = 5'd29;
   localparam reg_idx_t FP       = 5'd30;
   localparam reg_idx_t RA       = 5'd31;

   // True for any index that owns real storage. Index 0 is the only exception.
   function automatic logic is_writable(input reg_idx_t idx);
      return (idx != ZERO_REG);
   endfunction

endpackage : cpu_pkg

// File: rtl/reg_file_rd_port.sv
// -----------------------------------------------------------------------------
// reg_file_rd_port
//   This is one combinational read port of the register file. It selects one
//   entry from the flattened storage view. Address 0 always returns zero. When
//   BYPASS is set, the port forwards the in-flight write data if this port
//   reads the register being written in the same cycle.
//
// Ports
//   rd_addr  in   ADDR_W                  register index to read
//   entries  in   NUM_REGS x DATA_W       current storage (entry 0 is zero)
//   byp_en   in   1                       a real write is active this cycle
//                                         (enable, non-zero target, out of reset)
//   wr_addr  in   ADDR_W                  write target index
//   wr_data  in   DATA_W                  write data
//   rd_data  out  DATA_W                  selected value
// -----------------------------------------------------------------------------
module reg_file_rd_port #(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int ADDR_W = cpu_pkg::ADDR_W,
   parameter int BYPASS = 1
) (
   input  logic [ADDR_W-1:0]                    rd_addr,
   input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]   entries,
   input  logic                                 byp_en,
   input  logic [ADDR_W-1:0]                    wr_addr,
   input  logic [DATA_W-1:0]                    wr_data,
   output logic [DATA_W-1:0]                    rd_data
);

   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(cpu_pkg::ZERO_REG);

   logic hit_s;

   // Forwarding match. It is only meaningful when BYPASS is enabled. The
   // zero-address check happens below, so the zero force always wins.
   always_comb begin
      hit_s = 1'b0;
      if ((BYPASS != 0) && byp_en && (rd_addr == wr_addr)) begin
         hit_s = 1'b1;
      end else begin
         hit_s = 1'b0;
      end
   end

   // Read mux, with the zero force and the bypass select.
   always_comb begin
      rd_data = {DATA_W{1'b0}};
      if (rd_addr == ZERO_IDX) begin
         rd_data = {DATA_W{1'b0}};
      end else if (hit_s) begin
         rd_data = wr_data;
      end else begin
         rd_data = entries[rd_addr];
      end
   end

endmodule : reg_file_rd_port

// File: rtl/reg_file32.sv
// -----------------------------------------------------------------------------
// reg_file32
//   This is a 32-entry x 32-bit general-purpose register file with two
//   combinational read ports and one synchronous write port. Register 0 is
//   hardwired to zero and has no storage. An optional same-cycle
//   write-to-read bypass is selected by the BYPASS parameter.
//
// Ports
//   clk         in   1       rising-edge clock for writes
//   rst_n       in   1       asynchronous active-low reset, clears every entry
//   read_reg1   in   ADDR_W  read port 1 index (ALU operand A)
//   read_reg2   in   ADDR_W  read port 2 index (ALU operand B / store data)
//   write_reg   in   ADDR_W  write destination index
//   write_data  in   DATA_W  write-back value
//   reg_write   in   1       write enable
//   read_data1  out  DATA_W  value selected by read_reg1
//   read_data2  out  DATA_W  value selected by read_reg2
// -----------------------------------------------------------------------------
module reg_file32 #(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int ADDR_W = cpu_pkg::ADDR_W,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic              reg_write,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2
);

   localparam int                NUM_REGS = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(cpu_pkg::ZERO_REG);

   // Storage for entries 1..NUM_REGS-1 only. Entry 0 has no flops.
   logic [DATA_W-1:0]                 mem_r [1:NUM_REGS-1];
   logic [NUM_REGS-1:0][DATA_W-1:0]   entries_s;
   logic                              wr_en_s;
   logic                              byp_en_s;

   // Write qualification. Writes to index 0 are dropped here. Bypass also
   // needs rst_n high, so that no forwarding happens while the array is
   // held in reset.
   always_comb begin
      wr_en_s  = 1'b0;
      byp_en_s = 1'b0;
      if (reg_write && (write_reg != ZERO_IDX)) begin
         wr_en_s  = 1'b1;
         byp_en_s = rst_n;
      end else begin
         wr_en_s  = 1'b0;
         byp_en_s = 1'b0;
      end
   end

   // Storage array. Reset clears it asynchronously. Otherwise the decoded
   // entry captures write_data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (wr_en_s && (write_reg == ADDR_W'(i))) begin
               mem_r[i] <= write_data;
            end else begin
               mem_r[i] <= mem_r[i];
            end
         end
      end
   end

   // Flattened view for the read ports. Slot 0 is a constant zero.
   always_comb begin
      entries_s    = '0;
      entries_s[0] = {DATA_W{1'b0}};
      for (int i = 1; i < NUM_REGS; i++) begin
         entries_s[i] = mem_r[i];
      end
   end

   reg_file_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
   ) u_rd_port1 (
      .rd_addr (read_reg1),
      .entries (entries_s),
      .byp_en  (byp_en_s),
      .wr_addr (write_reg),
      .wr_data (write_data),
      .rd_data (read_data1)
   );

   reg_file_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
   ) u_rd_port2 (
      .rd_addr (read_reg2),
      .entries (entries_s),
      .byp_en  (byp_en_s),
      .wr_addr (write_reg),
      .wr_data (write_data),
      .rd_data (read_data2)
   );

endmodule : reg_file32

// File: tb/tb_reg_file32.sv
// -----------------------------------------------------------------------------
// tb_reg_file32
//   Self-checking bench for reg_file32. It runs two instances, one with
//   BYPASS=1 and one with BYPASS=0, driven by the same inputs. Both are
//   compared against an array-based reference model of the register file.
// -----------------------------------------------------------------------------
module tb_reg_file32;

   logic        clk;
   logic        rst_n;
   logic [4:0]  read_reg1;
   logic [4:0]  read_reg2;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic        reg_write;
   logic [31:0] rd1_byp, rd2_byp, rd1_nob, rd2_nob;

   int checks;
   int errors;

   // Reference model: architectural contents of every register.
   logic [31:0] model [32];

   reg_file32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_byp (
      .clk        (clk),
      .rst_n      (rst_n),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .write_reg  (write_reg),
      .write_data (write_data),
      .reg_write  (reg_write),
      .read_data1 (rd1_byp),
      .read_data2 (rd2_byp)
   );

   reg_file32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nob (
      .clk        (clk),
      .rst_n      (rst_n),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .write_reg  (write_reg),
      .write_data (write_data),
      .reg_write  (reg_write),
      .read_data1 (rd1_nob),
      .read_data2 (rd2_nob)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected read value, following the architectural rules directly.
   function automatic logic [31:0] expect_rd(input logic [4:0] a, input bit byp);
      if (a == 5'd0) return 32'd0;
      if (byp && rst_n && reg_write && (write_reg == a)) return write_data;
      return model[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
   endtask

   // Advance one rising edge, then apply the write rule to the model.
   task automatic edge_update();
      @(posedge clk);
      if (rst_n && reg_write && (write_reg != 5'd0)) model[write_reg] = write_data;
      #1;
   endtask

   task automatic idle_inputs();
      reg_write  = 1'b0;
      write_reg  = 5'd0;
      write_data = 32'd0;
      read_reg1  = 5'd0;
      read_reg2  = 5'd0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      model_clear();
      #12;
      for (int a = 0; a < 32; a++) begin
         read_reg1 = 5'(a);
         read_reg2 = 5'(31 - a);
         #1;
         checks++;
         if (rd1_byp !== 32'd0 || rd2_byp !== 32'd0 || rd1_nob !== 32'd0 || rd2_nob !== 32'd0) begin
            errors++;
            $display("FAIL reset_clear addr=%0d got %h %h %h %h want 0", a, rd1_byp, rd2_byp, rd1_nob, rd2_nob);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      @(negedge clk);
      reg_write = 1'b1; write_reg = 5'd1; write_data = 32'h0000_000F;
      edge_update();
      @(negedge clk);
      write_reg = 5'd2; write_data = 32'h0000_00F0;
      edge_update();
      @(negedge clk);
      idle_inputs();
      read_reg1 = 5'd1; read_reg2 = 5'd2;
      #1;
      checks++;
      if (rd1_byp !== 32'h0000_000F || rd2_byp !== 32'h0000_00F0 ||
          rd1_nob !== 32'h0000_000F || rd2_nob !== 32'h0000_00F0) begin
         errors++;
         $display("FAIL basic_rw got %h %h %h %h want 0000000f 000000f0", rd1_byp, rd2_byp, rd1_nob, rd2_nob);
      end
      checks++;
      if ((rd1_byp & rd2_byp) !== 32'd0) begin
         errors++;
         $display("FAIL basic_and got %h want 0", rd1_byp & rd2_byp);
      end
   endtask

   task automatic test_zero_reg();
      @(negedge clk);
      reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFF_FFFF;
      read_reg1 = 5'd0; read_reg2 = 5'd0;
      #1;
      checks++;
      if (rd1_byp !== 32'd0 || rd2_byp !== 32'd0) begin
         errors++;
         $display("FAIL zero_bypass got %h %h want 0", rd1_byp, rd2_byp);
      end
      edge_update();
      @(negedge clk);
      reg_write = 1'b0;
      #1;
      checks++;
      if (rd1_byp !== 32'd0 || rd1_nob !== 32'd0) begin
         errors++;
         $display("FAIL zero_after_write got %h %h want 0", rd1_byp, rd1_nob);
      end
   endtask

   task automatic test_bypass();
      @(negedge clk);
      reg_write = 1'b1; write_reg = 5'd7; write_data = 32'h1111_1111;
      edge_update();
      @(negedge clk);
      write_data = 32'h2222_2222;
      read_reg1 = 5'd7; read_reg2 = 5'd7;
      #1;
      checks++;
      if (rd1_byp !== 32'h2222_2222 || rd2_byp !== 32'h2222_2222) begin
         errors++;
         $display("FAIL bypass_pre got %h %h want 22222222", rd1_byp, rd2_byp);
      end
      checks++;
      if (rd1_nob !== 32'h1111_1111 || rd2_nob !== 32'h1111_1111) begin
         errors++;
         $display("FAIL nobypass_pre got %h %h want 11111111", rd1_nob, rd2_nob);
      end
      edge_update();
      checks++;
      if (rd1_nob !== 32'h2222_2222 || rd2_nob !== 32'h2222_2222 || rd1_byp !== 32'h2222_2222) begin
         errors++;
         $display("FAIL bypass_post got %h %h %h want 22222222", rd1_nob, rd2_nob, rd1_byp);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_write_disable();
      @(negedge clk);
      reg_write = 1'b0; write_reg = 5'd9; write_data = 32'hA5A5_A5A5;
      read_reg1 = 5'd9; read_reg2 = 5'd9;
      edge_update();
      checks++;
      if (rd1_byp !== 32'd0 || rd2_nob !== 32'd0) begin
         errors++;
         $display("FAIL write_disable got %h %h want 0", rd1_byp, rd2_nob);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         reg_write  = ($urandom_range(3, 0) != 0);
         write_reg  = 5'($urandom_range(31, 0));
         write_data = $urandom;
         read_reg1  = ($urandom_range(3, 0) == 0) ? write_reg : 5'($urandom_range(31, 0));
         read_reg2  = ($urandom_range(3, 0) == 0) ? write_reg : 5'($urandom_range(31, 0));
         #1;
         checks++;
         if (rd1_byp !== expect_rd(read_reg1, 1'b1) || rd2_byp !== expect_rd(read_reg2, 1'b1) ||
             rd1_nob !== expect_rd(read_reg1, 1'b0) || rd2_nob !== expect_rd(read_reg2, 1'b0)) begin
            errors++;
            $display("FAIL random_pre n=%0d r1=%0d r2=%0d got %h %h %h %h want %h %h %h %h", n, read_reg1, read_reg2,
                     rd1_byp, rd2_byp, rd1_nob, rd2_nob, expect_rd(read_reg1, 1'b1), expect_rd(read_reg2, 1'b1),
                     expect_rd(read_reg1, 1'b0), expect_rd(read_reg2, 1'b0));
         end
         edge_update();
         checks++;
         if (rd1_nob !== model[read_reg1] || rd2_nob !== model[read_reg2]) begin
            errors++;
            $display("FAIL random_post n=%0d got %h %h want %h %h", n, rd1_nob, rd2_nob, model[read_reg1], model[read_reg2]);
         end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hDEAD_BEEF;
      edge_update();
      @(negedge clk);
      idle_inputs();
      read_reg1 = 5'd5;
      #1;
      checks++;
      if (rd1_byp !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL async_pre got %h want deadbeef", rd1_byp);
      end
      #1;
      rst_n = 1'b0;
      model_clear();
      #1;
      checks++;
      if (rd1_byp !== 32'd0 || rd1_nob !== 32'd0) begin
         errors++;
         $display("FAIL async_clear got %h %h want 0", rd1_byp, rd1_nob);
      end
      for (int a = 0; a < 32; a++) begin
         read_reg2 = 5'(a);
         #1;
         checks++;
         if (rd2_byp !== 32'd0 || rd2_nob !== 32'd0) begin
            errors++;
            $display("FAIL async_all addr=%0d got %h %h want 0", a, rd2_byp, rd2_nob);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_collision();
      @(negedge clk);
      reg_write = 1'b1; write_reg = 5'd3; write_data = 32'h1234_5678;
      read_reg1 = 5'd3; read_reg2 = 5'd3;
      @(posedge clk);
      rst_n = 1'b0;
      model_clear();
      #1;
      checks++;
      if (rd1_byp !== 32'd0 || rd1_nob !== 32'd0) begin
         errors++;
         $display("FAIL collision_reset got %h %h want 0", rd1_byp, rd1_nob);
      end
      @(negedge clk);
      rst_n = 1'b1;
      reg_write = 1'b0;
      #1;
      checks++;
      if (rd1_byp !== 32'd0 || rd2_nob !== 32'd0) begin
         errors++;
         $display("FAIL collision_lost got %h %h want 0", rd1_byp, rd2_nob);
      end
      reg_write = 1'b1; write_data = 32'hCAFE_0003;
      edge_update();
      checks++;
      if (rd1_nob !== 32'hCAFE_0003 || rd2_byp !== 32'hCAFE_0003) begin
         errors++;
         $display("FAIL first_write got %h %h want cafe0003", rd1_nob, rd2_byp);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_zero_reg();
      test_bypass();
      test_write_disable();
      test_random();
      test_async_reset();
      test_collision();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_reg_file32
